sm_fg_node_pe: RTL and testbench
================================

// Module: sm_fg_node_pe
// PURPOSE
//  Pipelined polar-SC node processing element. Consumes sign-magnitude LLR pairs, as produced by
//  the two's-complement-to-sign-magnitude stage, and computes either the min-sum f-function or
//  the g-function. Result is a sign-magnitude LLR.
//  Sits directly downstream of the converter, between the LLR memory and the next tree level.
//  Full valid/ready flow control; 2-stage pipeline; one result per cycle sustained.
// PARAMETERS
//  W        9   LLR width incl. sign; bit W-1 = sign (1 = negative), bits W-2:0 = magnitude
// PORTS
//  clk        in   1   single clock, all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   input pair valid
//  in_ready   out  1   PE can accept the pair this cycle
//  a_sm       in   W   LLR alpha_a, sign-magnitude
//  b_sm       in   W   LLR alpha_b, sign-magnitude
//  mode       in   1   0 = f-function, 1 = g-function
//  u_hat      in   1   partial-sum bit; used only when mode=1
//  out_valid  out  1   result valid
//  out_ready  in   1   downstream accepts result
//  out_sm     out  W   result LLR, sign-magnitude
//  sat_count  out  16  (only with SM_PE_STATS_EN) number of saturated g results
// BEHAVIOUR
//  - Reset: out_valid=0, out_sm=0, both stage-valid flags=0, sat_count=0. in_ready=1 in the cycle after reset.
//  - Transfer: input when in_valid&in_ready; output when out_valid&out_ready.
//  - Pipeline: S1 registers operands and precomputes. S2 holds the result.
//  - A stage loads when it is empty or its content moves on in the same cycle.
//  - in_ready = !s1_v | (s1 moves to S2 this cycle). This is combinational from out_ready; no skid buffer.
//  - Latency: 2 cycles from accepted input to out_valid when there is no stall.
//  - Throughput: 1/cycle while out_ready=1.
//  - Ordering is preserved. No result is dropped or duplicated under any out_ready pattern.
//  - Held outputs: out_sm and out_valid stay stable while out_valid & !out_ready.
//  - Input normalisation: negative zero (sign=1, mag=0) is treated as +0.
//  - f (mode=0): sign = sa^sb; mag = min(ma,mb).
//  - g (mode=1): sa' = sa^u_hat, so alpha = b + (1-2u)a.
//    - If sa'==sb: mag = ma+mb, computed at W bits. Saturate to 2^(W-1)-1 on overflow. sign = sb.
//    - Else: mag = |ma-mb|; sign = sign of the larger-magnitude operand (sa' or sb).
//  - Output normalisation: any result with mag=0 has sign forced to 0, so -0 is never emitted.
//  - Reset mid-operation: both in-flight pairs are discarded. No output appears for them.
//  - Simultaneous in/out handshake with full pipe: S2 drains, S1 advances, new pair enters S1 in the same cycle.
// CONFIGURATION
//  SM_PE_STATS_EN defined:
//    - sat_count port exists.
//    - It increments when a g result that saturated transfers out (out_valid&out_ready).
//    - It sticks at 16'hFFFF and clears only on rst.
//  SM_PE_STATS_EN undefined:
//    - Port and counter are absent. Datapath and timing are identical.
// TESTING (W=9)
//  1. f: a=9'h06A (+106), b=9'h167 (-103) -> out_sm=9'h167 (-103), 2 cycles after accept.
//  2. g, u=0: a=+200 (9'h0C8), b=+100 (9'h064) -> saturates to 9'h0FF (+255).
//     With SM_PE_STATS_EN: sat_count 0->1.
//  3. g, u=1: a=+50 (9'h032), b=+20 (9'h014) -> 9'h11E (-30).
//     g, u=0: a=-40 (9'h128), b=+40 (9'h028) -> 9'h000 (not 9'h100).
//  4. Back-pressure: offer 6 f pairs back-to-back with out_ready=0 for 5 cycles.
//     Required: in_ready drops after 2 accepts; out_sm is held stable.
//     Then out_ready=1: all 6 results appear in order, one per cycle.
//  5. f with a=9'h100 (-0), b=9'h105 (-5) -> 9'h000.
//     Assert rst for 1 cycle with 2 pairs in flight -> out_valid=0 next cycle, no stale output afterwards.
//  6. Random 10k pairs with random in_valid/out_ready against a golden integer model.
//     Required: exact match, no loss, no duplication.

Source files
------------

// File: rtl/sm_fg_node_pe.sv
// Two-stage polar-SC node PE: min-sum f / g-function on sign-magnitude LLRs with valid/ready flow control.
// Define SM_PE_STATS_EN to add the sat_count port counting saturated g results that leave the PE.
module sm_fg_node_pe #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_sm,
    input  logic [W-1:0] b_sm,
    input  logic         mode,
    input  logic         u_hat,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sm
`ifdef SM_PE_STATS_EN
    ,
    output logic [15:0]  sat_count
`endif
);
    localparam int M = W - 1;

    logic [M-1:0] ma_new, mb_new;
    logic         sa_new, sb_new;

    logic         s1_v;
    logic         s1_mode;
    logic         s1_sa, s1_sb;
    logic [M-1:0] s1_ma, s1_mb;
    logic         s1_a_ge;
    logic [W-1:0] s1_sum;

    logic         s2_load_ok, s1_move;
    logic         res_sign;
    logic [M-1:0] res_mag;
    logic [W-1:0] res_sm;

    // -0 is folded to +0 here; for g the u_hat flip is applied to a's sign up front.
    assign ma_new = a_sm[M-1:0];
    assign mb_new = b_sm[M-1:0];
    assign sa_new = (a_sm[W-1] & (|ma_new)) ^ (mode & u_hat);
    assign sb_new = b_sm[W-1] & (|mb_new);

    assign s2_load_ok = !out_valid || out_ready;
    assign s1_move    = s1_v && s2_load_ok;
    assign in_ready   = !s1_v || s1_move;

    always_comb begin
        res_sign = 1'b0;
        res_mag  = '0;
        if (!s1_mode) begin
            res_sign = s1_sa ^ s1_sb;
            res_mag  = s1_a_ge ? s1_mb : s1_ma;
        end else if (s1_sa == s1_sb) begin
            res_sign = s1_sb;
            res_mag  = s1_sum[M] ? '1 : s1_sum[M-1:0];
        end else begin
            res_sign = s1_a_ge ? s1_sa : s1_sb;
            res_mag  = s1_a_ge ? (s1_ma - s1_mb) : (s1_mb - s1_ma);
        end
        res_sm = {res_sign & (|res_mag), res_mag};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v      <= 1'b0;
            out_valid <= 1'b0;
            out_sm    <= '0;
        end else begin
            if (in_ready) begin
                s1_v <= in_valid;
                if (in_valid) begin
                    s1_mode <= mode;
                    s1_sa   <= sa_new;
                    s1_sb   <= sb_new;
                    s1_ma   <= ma_new;
                    s1_mb   <= mb_new;
                    s1_a_ge <= (ma_new >= mb_new);
                    s1_sum  <= {1'b0, ma_new} + {1'b0, mb_new};
                end
            end
            if (s2_load_ok) begin
                out_valid <= s1_v;
                if (s1_v)
                    out_sm <= res_sm;
            end
        end
    end

`ifdef SM_PE_STATS_EN
    logic s1_sat, s2_sat;

    assign s1_sat = s1_mode && (s1_sa == s1_sb) && s1_sum[M];

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_sat    <= 1'b0;
            sat_count <= '0;
        end else begin
            if (s1_move)
                s2_sat <= s1_sat;
            if (out_valid && out_ready && s2_sat && (sat_count != 16'hFFFF))
                sat_count <= sat_count + 16'd1;
        end
    end
`else
    // Statistics disabled: no counter, datapath unchanged.
`endif

endmodule

// File: tb/tb_sm_fg_node_pe.sv
// Self-checking bench for sm_fg_node_pe: integer LLR model + scoreboard queue, directed and random traffic.
module tb_sm_fg_node_pe;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       mode = 1'b0;
    logic       u_hat = 1'b0;
    logic [8:0] a_sm = '0;
    logic [8:0] b_sm = '0;
    logic       in_ready, out_valid;
    logic [8:0] out_sm;
`ifdef SM_PE_STATS_EN
    logic [15:0] sat_count;
    int          exp_sat = 0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0] exp_q[$];
    logic       hold = 1'b0;
    logic [8:0] held_sm = '0;

    logic [8:0] va[$];
    logic [8:0] vb[$];
    logic       vm[$];
    logic       vu[$];

    sm_fg_node_pe #(.W(9)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_sm(a_sm), .b_sm(b_sm), .mode(mode), .u_hat(u_hat),
        .out_valid(out_valid), .out_ready(out_ready), .out_sm(out_sm)
`ifdef SM_PE_STATS_EN
        , .sat_count(sat_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result as a signed integer LLR: f = sign(a*b)*min(|a|,|b|), g = b +/- a clamped to +/-255.
    function automatic logic [9:0] model(input logic [8:0] a, input logic [8:0] b,
                                         input logic m, input logic u);
        int av, bv, r, mag;
        logic sat;
        sat = 1'b0;
        av = a[8] ? -int'(a[7:0]) : int'(a[7:0]);
        bv = b[8] ? -int'(b[7:0]) : int'(b[7:0]);
        if (!m) begin
            mag = (a[7:0] < b[7:0]) ? int'(a[7:0]) : int'(b[7:0]);
            r = ((av < 0) != (bv < 0)) ? -mag : mag;
        end else begin
            r = bv + (u ? -av : av);
            if (r > 255) begin r = 255; sat = 1'b1; end
            else if (r < -255) begin r = -255; sat = 1'b1; end
        end
        if (r < 0) return {sat, 1'b1, 8'(-r)};
        return {sat, 1'b0, 8'(r)};
    endfunction

    // Scoreboard: samples handshakes just before each rising edge.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                exp_q.delete();
                hold = 1'b0;
`ifdef SM_PE_STATS_EN
                exp_sat = 0;
`endif
            end else begin
                if (hold) begin
                    chk("hold_valid", int'(out_valid), 1);
                    chk("hold_sm", int'(out_sm), int'(held_sm));
                end
`ifdef SM_PE_STATS_EN
                chk("sat_count", int'(sat_count), exp_sat);
`endif
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", int'(out_sm), -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_sm", int'(out_sm), int'(e[8:0]));
`ifdef SM_PE_STATS_EN
                        if (e[9] && exp_sat != 16'hFFFF) exp_sat++;
`endif
                    end
                end
                if (in_valid && in_ready)
                    exp_q.push_back(model(a_sm, b_sm, mode, u_hat));
                hold = out_valid && !out_ready;
                held_sm = out_sm;
            end
        end
    end

    task automatic drive(input logic [8:0] a, input logic [8:0] b, input logic m, input logic u);
        a_sm = a; b_sm = b; mode = m; u_hat = u;
    endtask

    // Single pair through an empty pipe with literal expected result and 2-cycle latency.
    task automatic send_one(input string name, input logic [8:0] a, input logic [8:0] b,
                            input logic m, input logic u, input logic [8:0] exp);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        drive(a, b, m, u);
        chk({name, "_in_ready"}, int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({name, "_early_valid"}, int'(out_valid), 0);
        @(negedge clk);
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_sm"}, int'(out_sm), int'(exp));
    endtask

    task automatic stream(input int val_pct, input int rdy_pct, input int max_cycles);
        int idx, cyc;
        idx = 0;
        cyc = 0;
        while ((idx < va.size() || exp_q.size() != 0 || out_valid) && cyc < max_cycles) begin
            @(negedge clk);
            out_ready = ($urandom_range(99) < rdy_pct);
            if (idx < va.size() && $urandom_range(99) < val_pct) begin
                in_valid = 1'b1;
                drive(va[idx], vb[idx], vm[idx], vu[idx]);
            end else begin
                in_valid = 1'b0;
                drive(9'($urandom), 9'($urandom), 1'($urandom), 1'($urandom));
            end
            #4;
            if (in_valid && in_ready) idx++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("stream_timeout", cyc < max_cycles ? 1 : 0, 1);
        chk("stream_all_sent", idx, va.size());
    endtask

    initial begin
        int acc;
        drive('0, '0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sm", int'(out_sm), 0);
        chk("rst_in_ready", int'(in_ready), 1);
`ifdef SM_PE_STATS_EN
        chk("rst_sat_count", int'(sat_count), 0);
`endif

        send_one("f_basic", 9'h06A, 9'h167, 1'b0, 1'b0, 9'h167);
        send_one("g_sat", 9'h0C8, 9'h064, 1'b1, 1'b0, 9'h0FF);
`ifdef SM_PE_STATS_EN
        @(negedge clk);
        chk("sat_count_inc", int'(sat_count), 1);
`endif
        send_one("g_u1", 9'h032, 9'h014, 1'b1, 1'b1, 9'h11E);
        send_one("g_zero", 9'h128, 9'h028, 1'b1, 1'b0, 9'h000);
        send_one("g_255", 9'h0C8, 9'h037, 1'b1, 1'b0, 9'h0FF);
        send_one("f_negzero", 9'h100, 9'h105, 1'b0, 1'b0, 9'h000);
        send_one("g_negdiff", 9'h10A, 9'h003, 1'b1, 1'b0, 9'h107);

        // Back-pressure: six f pairs, downstream stalled for five cycles.
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid = 1'b1;
            drive(9'(10 * acc + 3), 9'h100 | 9'(5 + 7 * acc), 1'b0, 1'b0);
            #4;
            if (in_ready) acc++;
        end
        chk("bp_accepts", acc, 2);
        chk("bp_in_ready_low", int'(in_ready), 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            chk("bp_drain_valid", int'(out_valid), 1);
            if (acc < 6) begin
                in_valid = 1'b1;
                drive(9'(10 * acc + 3), 9'h100 | 9'(5 + 7 * acc), 1'b0, 1'b0);
            end else begin
                in_valid = 1'b0;
            end
            #4;
            if (in_valid && in_ready) acc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_all_accepted", acc, 6);
        chk("bp_drained", exp_q.size(), 0);

        // Reset with two pairs in flight.
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        drive(9'h040, 9'h020, 1'b0, 1'b0);
        @(negedge clk);
        drive(9'h050, 9'h030, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_valid", int'(out_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_valid", int'(out_valid), 0);
        chk("post_rst_in_ready", int'(in_ready), 1);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("no_stale_out", int'(out_valid), 0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 10000; i++) begin
            va.push_back(9'($urandom));
            vb.push_back(9'($urandom));
            vm.push_back(1'($urandom));
            vu.push_back(1'($urandom));
        end
        stream(70, 65, 60000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
